// File: rtl/lsu_pkg.sv
// +--------------------------------------------------------------------+
// | lsu_pkg : shared types, funct3 codes and fault check for lsu_rmw    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

   localparam int LSU_XLEN = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RMW_RD = 2'd2,
      WRITE  = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Misalignment depends only on the access size in funct3[1:0].
   function automatic logic lsu_fault(input logic is_load, input logic [2:0] f3,
                                      input logic [2:0] lo);
      logic flt;
      flt = 1'b0;
      if (is_load && f3 == 3'b111) begin
         flt = 1'b1;
      end else if (!is_load && f3[2]) begin
         flt = 1'b1;
      end else begin
         case (f3[1:0])
            2'b01:   flt = lo[0];
            2'b10:   flt = |lo[1:0];
            2'b11:   flt = |lo;
            default: flt = 1'b0;
         endcase
      end
      return flt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// +--------------------------------------------------------------------+
// | lsu_lane_align : combinational load extract/extend, store merge     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int XLEN = LSU_XLEN
) (
   input  logic [2:0]      funct3,
   input  logic [2:0]      offset,
   input  logic [XLEN-1:0] mem_word,
   input  logic [XLEN-1:0] store_data,
   output logic [XLEN-1:0] load_ext,
   output logic [XLEN-1:0] merged
);

   logic [5:0]      shamt;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] size_mask;
   logic [XLEN-1:0] lane_mask;

   assign shamt   = {offset, 3'b000};
   assign shifted = mem_word >> shamt;

   always_comb begin
      load_ext = shifted;
      case (funct3)
         F3_B:    load_ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
         F3_H:    load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_W:    load_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         F3_BU:   load_ext = {{(XLEN-8){1'b0}},  shifted[7:0]};
         F3_HU:   load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
         F3_WU:   load_ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   always_comb begin
      size_mask = '1;
      case (funct3[1:0])
         2'b00:   size_mask = {{(XLEN-8){1'b0}},  8'hFF};
         2'b01:   size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
         2'b10:   size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
         default: size_mask = '1;
      endcase
   end

   assign lane_mask = size_mask << shamt;
   assign merged    = (mem_word & ~lane_mask) | ((store_data & size_mask) << shamt);

endmodule

`default_nettype wire

// File: rtl/lsu_rmw.sv
// +--------------------------------------------------------------------+
// | lsu_rmw : load/store unit with sub-word read-modify-write stores    |
// | Optional macro LSU_TRACE_EN adds simulation trace output. Rev 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int XLEN           = LSU_XLEN,
   parameter int MEM_DEPTH_LOG2 = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            req_load,
   input  logic            req_store,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   output logic            stall,
   output logic            load_valid,
   output logic [XLEN-1:0] load_data,
   output logic            access_fault,
   output logic [XLEN-1:0] mem_address,
   output logic [XLEN-1:0] mem_data_in,
   output logic            MemWrite,
   output logic            MemRead,
   input  logic [XLEN-1:0] mem_data_out
);

   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_LOAD   = 2'(LOAD);
   localparam logic [1:0] ST_RMW_RD = 2'(RMW_RD);
   localparam logic [1:0] ST_WRITE  = 2'(WRITE);

   logic [1:0]      state;
   logic [2:0]      op_funct3;
   logic [XLEN-1:0] op_addr;
   logic [XLEN-1:0] op_data;

   logic            accept;
   logic            req_fault;
   logic [XLEN-1:0] req_index;
   logic [XLEN-1:0] load_ext;
   logic [XLEN-1:0] merged;

   assign stall    = (state != ST_IDLE);
   assign MemRead  = (state == ST_LOAD) || (state == ST_RMW_RD);
   assign MemWrite = (state == ST_WRITE);

   // A request carrying both load and store is serviced as a load.
   assign accept    = req_valid && !stall && (req_load || req_store);
   assign req_fault = lsu_fault(req_load, funct3, addr[2:0]);
   assign req_index = {{(XLEN-MEM_DEPTH_LOG2){1'b0}}, addr[MEM_DEPTH_LOG2+2:3]};

   lsu_lane_align #(
      .XLEN (XLEN)
   ) u_align (
      .funct3     (op_funct3),
      .offset     (op_addr[2:0]),
      .mem_word   (mem_data_out),
      .store_data (op_data),
      .load_ext   (load_ext),
      .merged     (merged)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         op_funct3    <= 3'b000;
         op_addr      <= '0;
         op_data      <= '0;
         load_valid   <= 1'b0;
         load_data    <= '0;
         access_fault <= 1'b0;
         mem_address  <= '0;
         mem_data_in  <= '0;
      end else begin
         load_valid   <= 1'b0;
         access_fault <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (req_fault) begin
                     access_fault <= 1'b1;
                  end else begin
                     op_funct3   <= funct3;
                     op_addr     <= addr;
                     op_data     <= store_data;
                     mem_address <= req_index;
                     if (req_load) begin
                        state <= ST_LOAD;
                     end else if (funct3 == F3_D) begin
                        mem_data_in <= store_data;
                        state       <= ST_WRITE;
                     end else begin
                        state <= ST_RMW_RD;
                     end
                  end
               end
            end
            ST_LOAD: begin
               load_data  <= load_ext;
               load_valid <= 1'b1;
               state      <= ST_IDLE;
            end
            ST_RMW_RD: begin
               mem_data_in <= merged;
               state       <= ST_WRITE;
            end
            ST_WRITE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef LSU_TRACE_EN
   always @(posedge clk) begin
      if (!reset && state == ST_WRITE) begin
         $display("lsu_rmw: write index=%0d data=%h", mem_address, mem_data_in);
      end
      if (!reset && load_valid) begin
         $display("lsu_rmw: load addr=%h data=%h", op_addr, load_data);
      end
   end
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^op_addr[XLEN-1:3];
`endif

endmodule

`default_nettype wire

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit directly upstream of the data memory in the pipelined RISC-V core.
- Takes a byte-addressed load/store from EX/MEM and drives the doubleword-indexed data memory (MemRead/MemWrite/address/data_in), which writes on negedge clk.
- Extracts and sign/zero-extends sub-word load data.
- Performs sub-word stores as a read-modify-write, stalling the pipeline while busy.

Parameters:
- XLEN, 64, data/address width.
- MEM_DEPTH_LOG2, 10, log2 of memory doublewords; index = addr[MEM_DEPTH_LOG2+2:3].

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- funct3  in  3  RISC-V funct3 of the load/store.
- addr  in  XLEN  byte address.
- store_data  in  XLEN  store source, low bytes used.
- stall  out  1  unit busy; request not accepted.
- load_valid  out  1  one-cycle pulse, load_data valid.
- load_data  out  XLEN  extended load result.
- access_fault  out  1  one-cycle pulse: misaligned or illegal funct3.
- mem_address  out  XLEN  doubleword index to memory, zero-extended.
- mem_data_in  out  XLEN  write data to memory.
- MemWrite  out  1  memory write enable.
- MemRead  out  1  memory read enable.
- mem_data_out  in  XLEN  combinational read data from memory.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States and transitions:
  - IDLE to LOAD on a load.
  - IDLE to WRITE on sd.
  - IDLE to RMW_RD on sb/sh/sw.
  - LOAD to IDLE; RMW_RD to WRITE; WRITE to IDLE.
- Accept: req_valid & ~stall in IDLE; address, funct3 and data are registered. stall = (state != IDLE), decoded from the state register.
- Request-type priority:
  - req_load & req_store both high: treated as a load.
  - req_valid with neither high: ignored.
- Memory controls:
  - MemRead = state in {LOAD, RMW_RD}.
  - MemWrite = (state == WRITE).
  - Both decode the state register only (no combinational path from req_*). mem_address and mem_data_in are registered and stable for the whole cycle.
- Load latency: accept at edge N, LOAD during cycle N..N+1. load_data is captured at edge N+1 and load_valid is high for the cycle after it.
- Load decode:
  - 000 lb and 100 lbu select byte addr[2:0].
  - 001 lh and 101 lhu select half addr[2:1].
  - 010 lw and 110 lwu select word addr[2].
  - 011 ld takes the full doubleword.
  - Signed variants sign-extend; u variants zero-extend.
- Store decode:
  - 000 sb, 001 sh, 010 sw, 011 sd.
  - Sub-word: RMW_RD captures mem_data_out and merges the store bytes at the lane given by addr[2:0]. The merged word goes to mem_data_in during WRITE.
  - sd: mem_data_in = store_data, no read.
- Alignment and legality faults:
  - Fault conditions: lh/lhu/sh with addr[0]; lw/lwu/sw with addr[1:0] != 0; ld/sd with addr[2:0] != 0; load funct3 111; store funct3 >= 100.
  - On a fault: access_fault pulses the cycle after accept, no MemRead/MemWrite, state stays IDLE, stall stays 0, load_valid stays 0.
- Address wrap: addr bits above MEM_DEPTH_LOG2+2 are ignored (modulo 8 KiB).
- Cycle counts:
  - Load occupancy: 2 cycles incl. accept.
  - sd: 2 cycles.
  - Sub-word store: 3 cycles.
  - Back-to-back requests: accepted on the first IDLE cycle.
- Reset mid-operation: state returns to IDLE at that edge. MemRead/MemWrite are 0 the following cycle, the pending store is dropped (never written), and load_valid is not raised.

Optional Feature:
- Macro: LSU_TRACE_EN.
- Defined: on every WRITE cycle, $display of index and merged data; on every load_valid, $display of byte address and load_data.
- Undefined: no simulation output; RTL is otherwise identical.

Decomposition:
- Shared package lsu_pkg:
  - state enum (IDLE, LOAD, RMW_RD, WRITE);
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - XLEN default.
- One sub-module, lsu_lane_align: purely combinational load extract/extend and store byte-merge, shared by the load and RMW paths.

Test Plan:
- Setup for all scenarios: preload memory index 2 = 0x8877665544332211 (bytes 0x10-0x17).
- ld addr 0x10 -> MemRead for 1 cycle, mem_address=2; next cycle load_valid=1, load_data=0x8877665544332211.
- lb addr 0x17 -> load_data=0xFFFFFFFFFFFFFF88; lbu addr 0x17 -> 0x0000000000000088; lhu addr 0x16 -> 0x8877.
- sh store_data=0xBEEF addr 0x12 -> stall high 2 cycles, MemRead then MemWrite, mem_data_in=0x88776655BEEF2211; index 2 then holds that value.
- lw addr 0x11 and sw funct3 111 -> access_fault pulse each, MemRead=MemWrite=0, stall=0.
- sb addr 0x10 with reset asserted during RMW_RD -> state IDLE next cycle, MemWrite never 1, index 2 unchanged.
- sd 0x0123456789ABCDEF addr 0x18, then ld addr 0x18 back-to-back -> load_data=0x0123456789ABCDEF.
